issue_buffer: RTL and testbench
===============================

# issue_buffer

Parametrised instruction buffer between fetch and the decode/issue stage. Accepts up to FETCH_W instructions per cycle and presents the oldest ISSUE_W entries to the issue logic. Retires however many entries the arbiter actually issued, so an un-issued second instruction stays at the head for the next cycle. Tags delay-slot instructions and withholds a jump/branch until its delay slot is also buffered; the issue logic never sees a branch without its slot.

## Interface
Parameters:
- DEPTH, 16: entries; power of two, ≥ 2·FETCH_W.
- FETCH_W, 2: instructions written per cycle.
- ISSUE_W, 2: head entries presented per cycle; ≤ DEPTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush_i  in  1  discard all entries (exception/mispredict redirect).
- stall_i  in  1  back-end stall; blocks dequeue only.
- fetch_valid_i  in  FETCH_W  per-slot valid; contiguous from bit 0.
- fetch_inst_i  in  32·FETCH_W  instructions, slot 0 oldest.
- fetch_addr_i  in  32·FETCH_W  instruction addresses.
- fetch_bpu_i  in  33·FETCH_W  branch-prediction info per slot.
- fetch_ready_o  out  1  free entries ≥ FETCH_W.
- out_valid_o  out  ISSUE_W  head slot k is presentable.
- out_inst_o  out  32·ISSUE_W  head instructions, slot 0 oldest.
- out_addr_o  out  32·ISSUE_W  head addresses.
- out_bpu_o  out  33·ISSUE_W  head prediction info.
- out_ds_o  out  ISSUE_W  slot k is a delay-slot instruction.
- issue_cnt_i  in  clog2(ISSUE_W+1)  number of head entries issued this cycle.
- count_o  out  clog2(DEPTH+1)  occupancy.

## Operation
- Storage: circular array of {inst, addr, bpu, ds, jb}. It has a head pointer and a tail pointer, each clog2(DEPTH) bits wide, which wrap modulo DEPTH. It also has an explicit count register.
- Enqueue: when fetch_ready_o is 1, n_in = popcount(fetch_valid_i) entries are written at tail..tail+n_in−1. tail advances by n_in.
  - If fetch_ready_o is 0, the inputs are ignored; fetch must hold them.
- Predecode: jb = the instruction is a J/JAL/JR/JALR/branch class; ds = jb of the previously enqueued instruction.
  - The jb of the previous instruction comes either from the preceding slot in the same write or from a last_jb register that carries it across cycles.
- Presentation: slot k shows entry head+k when k < count.
  - out_valid_o[k] = (k < count) and no presented slot j ≤ k has jb with j+1 ≥ count.
  - Effect: a branch whose delay slot is not yet buffered, and everything after it, is invalid.
  - Data outputs of invalid slots are zero.
- Dequeue: if stall_i is 0, n_out = min(issue_cnt_i, popcount(out_valid_o)) and head advances by n_out. If stall_i is 1, n_out = 0.
  - issue_cnt_i above the valid count is a protocol error: assert in simulation, clamp in RTL.
- count_next = count + n_in − n_out. Simultaneous enqueue and dequeue is legal.
- flush_i has priority over enqueue and dequeue. It sets head, tail, count and last_jb to 0. A fetch write in the same cycle is dropped.

## Timing
- Reset values: head = tail = count = 0, last_jb = 0. Outputs: out_valid_o = 0, out_* = 0, count_o = 0, fetch_ready_o = 1.
- fetch_ready_o is a function of registered count only; there is no combinational path from any input.
- Write-to-present latency: 1 cycle. An entry written at edge t is visible on out_* after edge t; there is no bypass.
- out_* depend combinationally on registered state only.
- Issue-to-retire: an entry counted in issue_cnt_i in cycle t disappears at edge t+1. Un-issued entries shift to slot 0 in cycle t+1.
- Full: count > DEPTH−FETCH_W forces fetch_ready_o = 0. Count never exceeds DEPTH.
- Empty: all out_valid_o = 0. issue_cnt_i is ignored.
- Reset asserted mid-operation clears the buffer immediately and asynchronously. No partial write survives.

## Structure
- Shared package holds:
  - the entry struct {inst[31:0], addr[31:0], bpu[32:0], ds, jb};
  - the MIPS opcode/funct constants;
  - the is_jb(inst) predecode function, which the id stage reuses.
- One sub-module, issue_buffer_ptr, is natural. It does pointer add modulo DEPTH and the count update; instance it for head and tail.

## Test plan
- Reset: rst = 0 for 3 cycles, then release → count_o = 0, out_valid_o = 0, fetch_ready_o = 1.
- Partial issue: write {addiu @0x100, addu @0x104}; the next cycle, issue_cnt_i = 1 → the following cycle slot 0 = 0x104, count_o = 1.
- Delay-slot hold, part 1: write {nop @0x200, beq @0x204} → out_valid_o = 01.
- Delay-slot hold, part 2: issue 1, then write {sw @0x208} → beq presented in slot 0 with valid 11, and out_ds_o[1] = 1 for 0x208.
- Full and wrap: DEPTH = 16; write 2 per cycle with issue_cnt_i = 0 → fetch_ready_o falls when count_o = 16.
  - Then issue 2 per cycle for 40 cycles while writing → addresses appear in strict order across pointer wrap.
- Flush priority: count_o = 6, and flush_i, fetch_valid_i = 11 and issue_cnt_i = 2 together → next cycle count_o = 0 and last_jb is cleared.
- Stall: stall_i = 1 with issue_cnt_i = 2 → head unchanged while enqueue continues; count_o increases by 2.

Source files
------------

// File: rtl/issue_buffer_pkg.sv
// Shared types and MIPS predecode helpers for the issue buffer and the id stage.
package issue_buffer_pkg;

  // One buffered instruction plus its predecode tags.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [32:0] bpu;
    logic        ds;   // sits in the delay slot of the previous instruction
    logic        jb;   // jump or branch; owns a delay slot
  } entry_t;

  // Primary opcodes (inst[31:26]).
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  // SPECIAL function codes (inst[5:0]).
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  // True for J/JAL/JR/JALR and every conditional branch. REGIMM branches
  // (BLTZ/BGEZ/BLTZAL/BGEZAL) have rt[3:1] == 0; the other REGIMM rt codes
  // are traps and carry no delay slot.
  function automatic logic is_jb(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    case (op)
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: return 1'b1;
      OP_REGIMM:  return (inst[19:17] == 3'b000);
      OP_SPECIAL: return (fn == FN_JR) || (fn == FN_JALR);
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_buffer_if.sv
// Fetch-side and issue-side signals of the issue buffer.
interface issue_buffer_if #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
);
  logic                         flush_i;
  logic                         stall_i;
  logic [FETCH_W-1:0]           fetch_valid_i;
  logic [32*FETCH_W-1:0]        fetch_inst_i;
  logic [32*FETCH_W-1:0]        fetch_addr_i;
  logic [33*FETCH_W-1:0]        fetch_bpu_i;
  logic                         fetch_ready_o;
  logic [ISSUE_W-1:0]           out_valid_o;
  logic [32*ISSUE_W-1:0]        out_inst_o;
  logic [32*ISSUE_W-1:0]        out_addr_o;
  logic [33*ISSUE_W-1:0]        out_bpu_o;
  logic [ISSUE_W-1:0]           out_ds_o;
  logic [$clog2(ISSUE_W+1)-1:0] issue_cnt_i;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  // The buffer itself.
  modport slave (
    input  flush_i, stall_i, fetch_valid_i, fetch_inst_i, fetch_addr_i,
           fetch_bpu_i, issue_cnt_i,
    output fetch_ready_o, out_valid_o, out_inst_o, out_addr_o, out_bpu_o,
           out_ds_o, count_o
  );

  // Fetch and issue logic driving the buffer.
  modport master (
    output flush_i, stall_i, fetch_valid_i, fetch_inst_i, fetch_addr_i,
           fetch_bpu_i, issue_cnt_i,
    input  fetch_ready_o, out_valid_o, out_inst_o, out_addr_o, out_bpu_o,
           out_ds_o, count_o
  );
endinterface

// File: rtl/issue_buffer_ptr.sv
// Wrapping add/subtract register used for the head, tail and occupancy count.
// Pointers wrap modulo 2**W, which is DEPTH when W = clog2(DEPTH).
module issue_buffer_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] inc,
  input  logic [W-1:0] dec,
  output logic [W-1:0] q
);

  // Clear wins over the arithmetic update.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else          q <= q + inc - dec;
  end

endmodule

// File: rtl/issue_buffer.sv
// Instruction buffer between fetch and decode/issue. Holds back a jump or
// branch until its delay slot is buffered, and retires only what issued.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH   = 16,  // power of two, >= 2*FETCH_W
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2    // <= DEPTH; must match the interface instance
) (
  input  logic           clk,
  input  logic           rst,
  issue_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic            last_jb_q;
  logic            last_jb_d;
  logic            ready;
  logic [CW-1:0]   n_in;
  logic [CW-1:0]   n_out;
  logic [CW-1:0]   n_valid;
  logic [CW-1:0]   iss;
  entry_t          wr_entry [FETCH_W];
  logic [ISSUE_W-1:0] valid;

  // Ready depends on registered occupancy only.
  assign ready = (count_q <= CW'(DEPTH - FETCH_W));

  // Predecode the fetch group and count how many entries are accepted.
  always_comb begin : predecode_c
    logic prev_jb;
    // NOTE: every variable gets a default first so no path infers a latch.
    prev_jb   = last_jb_q;
    last_jb_d = last_jb_q;
    n_in      = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      wr_entry[s].inst = bus.fetch_inst_i[32*s +: 32];
      wr_entry[s].addr = bus.fetch_addr_i[32*s +: 32];
      wr_entry[s].bpu  = bus.fetch_bpu_i[33*s +: 33];
      wr_entry[s].jb   = is_jb(bus.fetch_inst_i[32*s +: 32]);
      wr_entry[s].ds   = prev_jb;
      prev_jb          = wr_entry[s].jb;
      if (bus.fetch_valid_i[s]) begin
        n_in      = n_in + CW'(1);
        last_jb_d = wr_entry[s].jb;
      end
    end
    if (!ready || bus.flush_i) n_in = '0;
  end

  // Present the head entries; a branch without its buffered slot blocks itself
  // and everything younger.
  always_comb begin : present_c
    logic          stop;
    logic [PW-1:0] idx;
    entry_t        rd;
    stop            = 1'b0;
    n_valid         = '0;
    valid           = '0;
    bus.out_inst_o  = '0;
    bus.out_addr_o  = '0;
    bus.out_bpu_o   = '0;
    bus.out_ds_o    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      idx = head + PW'(k);
      rd  = mem[idx];
      if (k < int'(count_q)) begin
        if (rd.jb && (k + 1 >= int'(count_q))) stop = 1'b1;
        valid[k] = !stop;
      end
      if (valid[k]) begin
        n_valid                   = n_valid + CW'(1);
        bus.out_inst_o[32*k +: 32] = rd.inst;
        bus.out_addr_o[32*k +: 32] = rd.addr;
        bus.out_bpu_o[33*k +: 33]  = rd.bpu;
        bus.out_ds_o[k]            = rd.ds;
      end
    end
  end

  // Retire what actually issued, clamped to what was presented.
  always_comb begin
    iss = CW'(bus.issue_cnt_i);
    if (bus.stall_i || bus.flush_i) n_out = '0;
    else if (iss < n_valid)         n_out = iss;
    else                            n_out = n_valid;
  end

  assign bus.out_valid_o   = valid;
  assign bus.count_o       = count_q;
  assign bus.fetch_ready_o = ready;

  // Pointer increments fit in PW bits; truncation gives the modulo-DEPTH wrap.
  issue_buffer_ptr #(.W(PW)) u_head (
    .clk(clk), .rst(rst), .clr(bus.flush_i),
    .inc(n_out[PW-1:0]), .dec('0), .q(head)
  );

  issue_buffer_ptr #(.W(PW)) u_tail (
    .clk(clk), .rst(rst), .clr(bus.flush_i),
    .inc(n_in[PW-1:0]), .dec('0), .q(tail)
  );

  issue_buffer_ptr #(.W(CW)) u_count (
    .clk(clk), .rst(rst), .clr(bus.flush_i),
    .inc(n_in), .dec(n_out), .q(count_q)
  );

  // Remember whether the last accepted instruction needs a delay slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                last_jb_q <= 1'b0;
    else if (bus.flush_i)    last_jb_q <= 1'b0;
    else if (n_in != '0)     last_jb_q <= last_jb_d;
  end

  // Write the accepted fetch slots at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count and the pointers mark which entries are live.
    for (int s = 0; s < FETCH_W; s++) begin
      if (CW'(s) < n_in) mem[tail + PW'(s)] <= wr_entry[s];
    end
  end

  // Issuing more than was presented is a protocol error; the RTL clamps it.
  issue_cnt_legal_a: assert property (@(posedge clk) disable iff (!rst)
    (!bus.flush_i && !bus.stall_i && count_q != '0) |-> (iss <= n_valid));

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer with DEPTH=16, FETCH_W=2, ISSUE_W=2.
module tb_issue_buffer;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADDIU = 32'h2401_0001;
  localparam logic [31:0] ADDU  = 32'h0022_1821;
  localparam logic [31:0] BEQ   = 32'h1022_0003;
  localparam logic [31:0] SW    = 32'hAC22_0000;
  localparam logic [31:0] JR    = 32'h03E0_0008;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  issue_buffer_if #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2)) bus ();

  issue_buffer #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] a0,
                       input logic [31:0] i1, input logic [31:0] a1,
                       input logic [1:0] ic, input logic st, input logic fl);
    bus.fetch_valid_i = v;
    bus.fetch_inst_i  = {i1, i0};
    bus.fetch_addr_i  = {a1, a0};
    bus.fetch_bpu_i   = '0;
    bus.issue_cnt_i   = ic;
    bus.stall_i       = st;
    bus.flush_i       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    checks++; if (bus.out_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", bus.out_valid_o); end
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.fetch_ready_o); end
    checks++; if (bus.out_addr_o !== 64'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.out_addr_o); end
  endtask

  task automatic test_partial_issue();
    drive(2'b11, ADDIU, 32'h100, ADDU, 32'h104, 2'd0, 1'b0, 1'b0);
    bus.fetch_bpu_i = {33'h0, 33'h1_2345_6789};
    tick();
    checks++; if (bus.out_valid_o !== 2'b11) begin errors++; $display("FAIL pi_valid got %b want 11", bus.out_valid_o); end
    checks++; if (bus.out_addr_o[31:0] !== 32'h100) begin errors++; $display("FAIL pi_addr0 got %h want 100", bus.out_addr_o[31:0]); end
    checks++; if (bus.out_bpu_o[32:0] !== 33'h1_2345_6789) begin errors++; $display("FAIL pi_bpu0 got %h want 123456789", bus.out_bpu_o[32:0]); end
    drive(2'b00, NOP, 0, NOP, 0, 2'd1, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_addr_o[31:0] !== 32'h104) begin errors++; $display("FAIL pi_head got %h want 104", bus.out_addr_o[31:0]); end
    checks++; if (bus.out_inst_o[31:0] !== ADDU) begin errors++; $display("FAIL pi_inst got %h want %h", bus.out_inst_o[31:0], ADDU); end
    checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL pi_count got %0d want 1", bus.count_o); end
    checks++; if (bus.out_valid_o !== 2'b01) begin errors++; $display("FAIL pi_valid1 got %b want 01", bus.out_valid_o); end
    tick();
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL pi_drain got %0d want 0", bus.count_o); end
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_issue();
    drive(2'b11, NOP, 32'h600, NOP, 32'h604, 2'd2, 1'b0, 1'b0);
    tick();
    checks++; if (bus.count_o !== 5'd2) begin errors++; $display("FAIL empty_issue_count got %0d want 2", bus.count_o); end
    checks++; if (bus.out_addr_o[31:0] !== 32'h600) begin errors++; $display("FAIL empty_issue_addr got %h want 600", bus.out_addr_o[31:0]); end
    drive(2'b00, NOP, 0, NOP, 0, 2'd2, 1'b0, 1'b0);
    tick();
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_delay_slot();
    drive(2'b11, NOP, 32'h200, BEQ, 32'h204, 2'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_valid_o !== 2'b01) begin errors++; $display("FAIL ds_hold_valid got %b want 01", bus.out_valid_o); end
    checks++; if (bus.out_addr_o[63:32] !== 32'h0) begin errors++; $display("FAIL ds_hold_zero got %h want 0", bus.out_addr_o[63:32]); end
    drive(2'b00, NOP, 0, NOP, 0, 2'd1, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_valid_o !== 2'b00) begin errors++; $display("FAIL ds_alone_valid got %b want 00", bus.out_valid_o); end
    checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL ds_alone_count got %0d want 1", bus.count_o); end
    drive(2'b01, SW, 32'h208, NOP, 0, 2'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_valid_o !== 2'b11) begin errors++; $display("FAIL ds_pair_valid got %b want 11", bus.out_valid_o); end
    checks++; if (bus.out_addr_o !== {32'h208, 32'h204}) begin errors++; $display("FAIL ds_pair_addr got %h want 0000020800000204", bus.out_addr_o); end
    checks++; if (bus.out_ds_o !== 2'b10) begin errors++; $display("FAIL ds_pair_tag got %b want 10", bus.out_ds_o); end
    checks++; if (bus.out_inst_o[31:0] !== BEQ) begin errors++; $display("FAIL ds_pair_inst got %h want %h", bus.out_inst_o[31:0], BEQ); end
    drive(2'b00, NOP, 0, NOP, 0, 2'd2, 1'b0, 1'b0);
    tick();
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_same_write_ds();
    drive(2'b11, JR, 32'h300, NOP, 32'h304, 2'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_valid_o !== 2'b11) begin errors++; $display("FAIL sw_ds_valid got %b want 11", bus.out_valid_o); end
    checks++; if (bus.out_ds_o !== 2'b10) begin errors++; $display("FAIL sw_ds_tag got %b want 10", bus.out_ds_o); end
    drive(2'b00, NOP, 0, NOP, 0, 2'd2, 1'b0, 1'b0);
    tick();
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_full_wrap();
    logic [31:0] next_wr;
    logic [31:0] next_rd;
    int          mc;
    bit          exp_ready;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.fetch_ready_o !== 1'b1 || bus.count_o !== 5'(2 * i)) begin
        errors++; $display("FAIL fill_%0d got ready %b count %0d want ready 1 count %0d", i, bus.fetch_ready_o, bus.count_o, 2 * i);
      end
      drive(2'b11, NOP, 32'h1000 + 32'(8 * i), NOP, 32'h1004 + 32'(8 * i), 2'd0, 1'b0, 1'b0);
      tick();
    end
    checks++; if (bus.count_o !== 5'd16 || bus.fetch_ready_o !== 1'b0) begin
      errors++; $display("FAIL full got count %0d ready %b want 16 0", bus.count_o, bus.fetch_ready_o);
    end
    drive(2'b11, NOP, 32'hDEAD_0000, NOP, 32'hDEAD_0004, 2'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL full_hold got %0d want 16", bus.count_o); end
    next_wr = 32'h1040;
    next_rd = 32'h1000;
    mc      = 16;
    for (int c = 0; c < 40; c++) begin
      exp_ready = (mc <= 14);
      checks++; if (bus.fetch_ready_o !== exp_ready || bus.count_o !== 5'(mc)) begin
        errors++; $display("FAIL wrap_state_%0d got ready %b count %0d want %b %0d", c, bus.fetch_ready_o, bus.count_o, exp_ready, mc);
      end
      checks++; if (bus.out_addr_o !== {next_rd + 32'd4, next_rd} || bus.out_valid_o !== 2'b11) begin
        errors++; $display("FAIL wrap_addr_%0d got %h valid %b want %h %h valid 11", c, bus.out_addr_o, bus.out_valid_o, next_rd + 32'd4, next_rd);
      end
      drive(2'b11, NOP, next_wr, NOP, next_wr + 32'd4, 2'd2, 1'b0, 1'b0);
      tick();
      if (exp_ready) begin
        next_wr += 32'd8;
        mc += 2;
      end
      mc -= 2;
      next_rd += 32'd8;
    end
    drive(2'b00, NOP, 0, NOP, 0, 2'd2, 1'b0, 1'b0);
    while (mc > 0) begin
      checks++; if (bus.out_addr_o !== {next_rd + 32'd4, next_rd}) begin
        errors++; $display("FAIL drain_addr got %h want %h %h", bus.out_addr_o, next_rd + 32'd4, next_rd);
      end
      tick();
      mc -= 2;
      next_rd += 32'd8;
    end
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL drain_count got %0d want 0", bus.count_o); end
  endtask

  task automatic test_flush();
    drive(2'b11, NOP, 32'h400, NOP, 32'h404, 2'd0, 1'b0, 1'b0);
    tick();
    drive(2'b11, NOP, 32'h408, NOP, 32'h40C, 2'd0, 1'b0, 1'b0);
    tick();
    drive(2'b11, NOP, 32'h410, BEQ, 32'h414, 2'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.count_o !== 5'd6) begin errors++; $display("FAIL flush_pre got %0d want 6", bus.count_o); end
    drive(2'b11, NOP, 32'hBAD0, NOP, 32'hBAD4, 2'd2, 1'b0, 1'b1);
    tick();
    checks++; if (bus.count_o !== 5'd0 || bus.out_valid_o !== 2'b00 || bus.fetch_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_state got count %0d valid %b ready %b want 0 00 1", bus.count_o, bus.out_valid_o, bus.fetch_ready_o);
    end
    drive(2'b11, ADDU, 32'h420, ADDU, 32'h424, 2'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_ds_o !== 2'b00) begin errors++; $display("FAIL flush_last_jb got ds %b want 00", bus.out_ds_o); end
    checks++; if (bus.out_addr_o[31:0] !== 32'h420 || bus.count_o !== 5'd2) begin
      errors++; $display("FAIL flush_refill got addr %h count %0d want 420 2", bus.out_addr_o[31:0], bus.count_o);
    end
    drive(2'b00, NOP, 0, NOP, 0, 2'd2, 1'b0, 1'b0);
    tick();
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    drive(2'b11, NOP, 32'h500, NOP, 32'h504, 2'd0, 1'b0, 1'b0);
    tick();
    drive(2'b11, NOP, 32'h508, NOP, 32'h50C, 2'd2, 1'b1, 1'b0);
    tick();
    checks++; if (bus.count_o !== 5'd4) begin errors++; $display("FAIL stall_count got %0d want 4", bus.count_o); end
    checks++; if (bus.out_addr_o[31:0] !== 32'h500) begin errors++; $display("FAIL stall_head got %h want 500", bus.out_addr_o[31:0]); end
    drive(2'b00, NOP, 0, NOP, 0, 2'd2, 1'b0, 1'b0);
    tick();
    checks++; if (bus.count_o !== 5'd2 || bus.out_addr_o[31:0] !== 32'h508) begin
      errors++; $display("FAIL unstall got count %0d addr %h want 2 508", bus.count_o, bus.out_addr_o[31:0]);
    end
    tick();
    drive(2'b00, NOP, 0, NOP, 0, 2'd0, 1'b0, 1'b0);
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL stall_drain got %0d want 0", bus.count_o); end
  endtask

  initial begin
    test_reset();
    test_partial_issue();
    test_empty_issue();
    test_delay_slot();
    test_same_write_ds();
    test_full_wrap();
    test_flush();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
